// File: rtl/vcgc_pkg.sv
// Shared types and constants for the vertex-colouring backtracking search.
// Optional cycle budget is enabled with the VCGC_CYCLE_LIMIT_EN macro.
package vcgc_pkg;

    localparam int NUM_V_DEF   = 30;
    localparam int COLOR_W_DEF = 2;
    localparam int NCOL        = 2 ** COLOR_W_DEF;

    typedef enum logic [1:0] {
        IDLE,
        ASSIGN,
        BACKTRACK,
        DONE
    } state_t;

    typedef logic [COLOR_W_DEF-1:0]        color_t;
    typedef logic [$clog2(NUM_V_DEF)-1:0]  vidx_t;

    // Number of colours for a given colour width.
    function automatic int ncol_of(input int color_w);
        return 1 << color_w;
    endfunction

endpackage

// File: rtl/vcgc_color_search_if.sv
// Edge-load / search-control bus of the backtracking colourer.
// slave = the colourer, master = whoever loads the graph and starts the search.
interface vcgc_color_search_if #(
    parameter int NUM_V   = 30,
    parameter int COLOR_W = 2
);
    localparam int VW = $clog2(NUM_V);

    logic                     clr_i;
    logic                     edge_valid;
    logic                     edge_ready;
    logic [VW-1:0]            edge_u;
    logic [VW-1:0]            edge_v;
    logic                     start_i;
    logic                     busy_o;
    logic                     done_o;
    logic                     success_o;
    logic                     timeout_o;
    logic [NUM_V*COLOR_W-1:0] color_o;

    modport master (
        output clr_i, edge_valid, edge_u, edge_v, start_i,
        input  edge_ready, busy_o, done_o, success_o, timeout_o, color_o
    );

    modport slave (
        input  clr_i, edge_valid, edge_u, edge_v, start_i,
        output edge_ready, busy_o, done_o, success_o, timeout_o, color_o
    );

endinterface

// File: rtl/vcgc_conflict_check.sv
// Combinational conflict test: does candidate colour cand clash with any
// already-coloured neighbour u < v of vertex v?
module vcgc_conflict_check
    import vcgc_pkg::*;
#(
    parameter int NUM_V   = 30,
    parameter int COLOR_W = 2,
    localparam int VW     = $clog2(NUM_V)
) (
    input  logic [NUM_V-1:0]         adj_row,
    input  logic [NUM_V*COLOR_W-1:0] colors,
    input  logic [VW-1:0]            v,
    input  logic [COLOR_W-1:0]       cand,
    output logic                     conflict
);

    always_comb begin
        // NOTE: assigning a default before the loop keeps this purely combinational (no latch).
        conflict = 1'b0;
        for (int u = 0; u < NUM_V; u++) begin
            if ((u < int'(v)) && adj_row[u] && (colors[COLOR_W*u +: COLOR_W] == cand)) begin
                conflict = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vcgc_color_search.sv
// Sequential backtracking vertex colourer: loads a graph edge by edge, searches for
// the lexicographically first proper colouring. VCGC_CYCLE_LIMIT_EN adds a cycle budget.
module vcgc_color_search
    import vcgc_pkg::*;
#(
    parameter int NUM_V   = 30,
    parameter int COLOR_W = 2
`ifdef VCGC_CYCLE_LIMIT_EN
    ,
    parameter int MAX_CYCLES = 65535
`endif
) (
    input logic                clk,
    input logic                rst,
    vcgc_color_search_if.slave bus
);

    localparam int                 VW       = $clog2(NUM_V);
    localparam logic [VW-1:0]      LAST_V   = VW'(NUM_V - 1);
    localparam logic [COLOR_W-1:0] CAND_MAX = COLOR_W'(ncol_of(COLOR_W) - 1);

    state_t                   state;
    logic [NUM_V-1:0]         adj [NUM_V];
    logic [NUM_V*COLOR_W-1:0] col_q;
    logic [VW-1:0]            v_q;
    logic [COLOR_W-1:0]       cand_q;
    logic                     ready_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     success_q;
    logic                     conflict;
    logic                     edge_ok;
    logic [COLOR_W-1:0]       prev_col;
`ifdef VCGC_CYCLE_LIMIT_EN
    logic [31:0]              cyc_q;
    logic                     timeout_q;
    logic                     budget_hit;

    assign budget_hit = (cyc_q + 32'd1) >= 32'(MAX_CYCLES);
`endif

    // Self-loops and out-of-range endpoints never reach the matrix.
    assign edge_ok = bus.edge_valid && (bus.edge_u != bus.edge_v) &&
                     (int'(bus.edge_u) < NUM_V) && (int'(bus.edge_v) < NUM_V);

    always_comb begin
        prev_col = '0;
        if (v_q != '0) begin
            prev_col = col_q[COLOR_W*(int'(v_q) - 1) +: COLOR_W];
        end
    end

    vcgc_conflict_check #(
        .NUM_V   (NUM_V),
        .COLOR_W (COLOR_W)
    ) u_conflict_check (
        .adj_row  (adj[v_q]),
        .colors   (col_q),
        .v        (v_q),
        .cand     (cand_q),
        .conflict (conflict)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            // NOTE: the adjacency matrix is reset explicitly because reset must leave an empty graph.
            for (int i = 0; i < NUM_V; i++) begin
                adj[i] <= '0;
            end
            col_q     <= '0;
            v_q       <= '0;
            cand_q    <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            success_q <= 1'b0;
`ifdef VCGC_CYCLE_LIMIT_EN
            cyc_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    // Clear wins over a same-cycle edge write; the matrix stays symmetric.
                    for (int i = 0; i < NUM_V; i++) begin
                        for (int j = 0; j < NUM_V; j++) begin
                            if (bus.clr_i) begin
                                adj[i][j] <= 1'b0;
                            end else if (edge_ok &&
                                         (((i == int'(bus.edge_u)) && (j == int'(bus.edge_v))) ||
                                          ((i == int'(bus.edge_v)) && (j == int'(bus.edge_u))))) begin
                                adj[i][j] <= 1'b1;
                            end
                        end
                    end
                    if (bus.start_i) begin
                        state     <= ASSIGN;
                        v_q       <= '0;
                        cand_q    <= '0;
                        col_q     <= '0;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        success_q <= 1'b0;
`ifdef VCGC_CYCLE_LIMIT_EN
                        cyc_q     <= '0;
                        timeout_q <= 1'b0;
`endif
                    end
                end

                ASSIGN: begin
                    if (!conflict) begin
                        col_q[COLOR_W*int'(v_q) +: COLOR_W] <= cand_q;
                        if (v_q == LAST_V) begin
                            state     <= DONE;
                            ready_q   <= 1'b1;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            success_q <= 1'b1;
                        end else begin
                            v_q    <= v_q + VW'(1);
                            cand_q <= '0;
                        end
                    end else if (cand_q == CAND_MAX) begin
                        state <= BACKTRACK;
                    end else begin
                        cand_q <= cand_q + COLOR_W'(1);
                    end
                end

                BACKTRACK: begin
                    if (v_q == '0) begin
                        state     <= DONE;
                        ready_q   <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        success_q <= 1'b0;
                    end else begin
                        v_q <= v_q - VW'(1);
                        // A predecessor already at the last colour is exhausted: keep unwinding.
                        if (prev_col != CAND_MAX) begin
                            cand_q <= prev_col + COLOR_W'(1);
                            state  <= ASSIGN;
                        end
                    end
                end

                default: state <= IDLE;
            endcase

`ifdef VCGC_CYCLE_LIMIT_EN
            // Budget exhaustion overrides whatever the search step decided this cycle.
            if ((state == ASSIGN) || (state == BACKTRACK)) begin
                cyc_q <= cyc_q + 32'd1;
                if (budget_hit) begin
                    state     <= DONE;
                    ready_q   <= 1'b1;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    success_q <= 1'b0;
                    timeout_q <= 1'b1;
                end
            end
`endif
        end
    end

    assign bus.edge_ready = ready_q;
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.success_o  = success_q;
    assign bus.color_o    = col_q;
`ifdef VCGC_CYCLE_LIMIT_EN
    assign bus.timeout_o  = timeout_q;
`else
    assign bus.timeout_o  = 1'b0;
`endif

endmodule

// File: tb/tb_vcgc_color_search.sv
// Bench for vcgc_color_search: directed graphs plus random small graphs checked against
// an exhaustive lexicographic colouring model. VCGC_CYCLE_LIMIT_EN adds a budget test.
module tb_vcgc_color_search;
    import vcgc_pkg::*;

    localparam int NV     = 30;
    localparam int CW     = 2;
    localparam int VW     = $clog2(NV);
    localparam int BUDGET = 20000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vcgc_color_search_if #(.NUM_V(NV), .COLOR_W(CW)) bus();

    vcgc_color_search #(.NUM_V(NV), .COLOR_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef VCGC_CYCLE_LIMIT_EN
    vcgc_color_search_if #(.NUM_V(NV), .COLOR_W(CW)) bus_t();

    vcgc_color_search #(.NUM_V(NV), .COLOR_W(CW), .MAX_CYCLES(10)) dut_t (
        .clk (clk),
        .rst (rst),
        .bus (bus_t)
    );
`endif

    int checks   = 0;
    int failures = 0;
    bit mg [NV][NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Proper-colouring test over the model graph (the downstream validity checker's view).
    function automatic bit is_proper(input logic [NV*CW-1:0] c);
        for (int i = 0; i < NV; i++)
            for (int j = i + 1; j < NV; j++)
                if (mg[i][j] && (c[CW*i +: CW] == c[CW*j +: CW])) return 1'b0;
        return 1'b1;
    endfunction

    // First proper colouring of vertices 0..n-1 in lexicographic order (v0 most significant);
    // all other vertices are assumed isolated and stay at colour 0.
    function automatic bit lex_first(input int n, output logic [NV*CW-1:0] cv);
        int               total;
        logic [NV*CW-1:0] c;
        total = 1 << (CW * n);
        for (int code = 0; code < total; code++) begin
            c = '0;
            for (int k = 0; k < n; k++) c[CW*k +: CW] = CW'(code >> (CW * (n - 1 - k)));
            if (is_proper(c)) begin
                cv = c;
                return 1'b1;
            end
        end
        cv = '0;
        return 1'b0;
    endfunction

    task automatic add_edge(input int u, input int v);
        bus.edge_valid = 1'b1;
        bus.edge_u     = VW'(u);
        bus.edge_v     = VW'(v);
        tick();
        bus.edge_valid = 1'b0;
        if ((u != v) && (u < NV) && (v < NV)) begin
            mg[u][v] = 1'b1;
            mg[v][u] = 1'b1;
        end
    endtask

    task automatic clear_graph();
        bus.clr_i = 1'b1;
        tick();
        bus.clr_i = 1'b0;
        for (int i = 0; i < NV; i++)
            for (int j = 0; j < NV; j++) mg[i][j] = 1'b0;
    endtask

    // Pulses start, returns the number of clock edges after the start edge until done_o.
    task automatic run_search(input string tag, output int n);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        n = 0;
        while (!bus.done_o && (n < BUDGET)) begin
            tick();
            n++;
        end
        check({tag, "_in_budget"}, 64'(n < BUDGET), 64'd1);
    endtask

    initial begin
        int               n;
        bit               ok;
        logic [NV*CW-1:0] cv;

        rst            = 1'b1;
        bus.clr_i      = 1'b0;
        bus.edge_valid = 1'b0;
        bus.edge_u     = '0;
        bus.edge_v     = '0;
        bus.start_i    = 1'b0;
`ifdef VCGC_CYCLE_LIMIT_EN
        bus_t.clr_i      = 1'b0;
        bus_t.edge_valid = 1'b0;
        bus_t.edge_u     = '0;
        bus_t.edge_v     = '0;
        bus_t.start_i    = 1'b0;
`endif
        for (int i = 0; i < NV; i++)
            for (int j = 0; j < NV; j++) mg[i][j] = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_edge_ready", 64'(bus.edge_ready), 64'd1);
        check("rst_busy",       64'(bus.busy_o),     64'd0);
        check("rst_done",       64'(bus.done_o),     64'd0);
        check("rst_success",    64'(bus.success_o),  64'd0);
        check("rst_timeout",    64'(bus.timeout_o),  64'd0);
        check("rst_color",      64'(bus.color_o),    64'd0);

        // Edgeless graph: done exactly NUM_V edges after the start edge
        run_search("edgeless", n);
        check("edgeless_cycles",  64'(n),              64'd30);
        check("edgeless_success", 64'(bus.success_o),  64'd1);
        check("edgeless_timeout", 64'(bus.timeout_o),  64'd0);
        check("edgeless_color",   64'(bus.color_o),    64'd0);
        check("edgeless_busy",    64'(bus.busy_o),     64'd0);
        check("edgeless_ready",   64'(bus.edge_ready), 64'd1);
        repeat (3) tick();
        check("done_level_held",  64'(bus.done_o),     64'd1);

        // K4: colours 0,1,2,3 on v0..v3
        add_edge(0, 1); add_edge(0, 2); add_edge(0, 3);
        add_edge(1, 2); add_edge(1, 3); add_edge(2, 3);
        run_search("k4", n);
        check("k4_success", 64'(bus.success_o), 64'd1);
        check("k4_color",   64'(bus.color_o),   64'h0E4);
        ok = lex_first(4, cv);
        check("k4_model",   64'(bus.color_o),   64'(cv));

        // K5 is not 4-colourable: exhaustive failure, no timeout
        clear_graph();
        for (int i = 0; i < 5; i++)
            for (int j = i + 1; j < 5; j++) add_edge(i, j);
        run_search("k5", n);
        ok = lex_first(5, cv);
        check("k5_done",    64'(bus.done_o),    64'd1);
        check("k5_success", 64'(bus.success_o), 64'(ok));
        check("k5_timeout", 64'(bus.timeout_o), 64'd0);

        // Dropped edges: self-loop and out-of-range endpoint leave the graph empty
        clear_graph();
        add_edge(3, 3);
        add_edge(31, 2);
        add_edge(2, 31);
        run_search("dropped", n);
        check("dropped_cycles",  64'(n),             64'd30);
        check("dropped_success", 64'(bus.success_o), 64'd1);
        check("dropped_color",   64'(bus.color_o),   64'd0);

        // clr beats a same-cycle edge write
        bus.clr_i      = 1'b1;
        bus.edge_valid = 1'b1;
        bus.edge_u     = VW'(0);
        bus.edge_v     = VW'(1);
        tick();
        bus.clr_i      = 1'b0;
        bus.edge_valid = 1'b0;
        run_search("clr_prio", n);
        check("clr_prio_color", 64'(bus.color_o), 64'd0);

        // start with a same-cycle edge: search sees the edge (v1 needs one extra step)
        bus.start_i    = 1'b1;
        bus.edge_valid = 1'b1;
        bus.edge_u     = VW'(0);
        bus.edge_v     = VW'(1);
        tick();
        bus.start_i    = 1'b0;
        bus.edge_valid = 1'b0;
        n = 0;
        while (!bus.done_o && (n < BUDGET)) begin
            tick();
            n++;
        end
        check("start_edge_cycles", 64'(n),           64'd31);
        check("start_edge_color",  64'(bus.color_o), 64'h4);

        // Controls ignored while busy: search length and result unaffected
        clear_graph();
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        repeat (4) tick();
        check("busy_mid", 64'(bus.busy_o), 64'd1);
        check("ready_mid", 64'(bus.edge_ready), 64'd0);
        bus.start_i    = 1'b1;
        bus.clr_i      = 1'b1;
        bus.edge_valid = 1'b1;
        bus.edge_u     = VW'(0);
        bus.edge_v     = VW'(1);
        tick();
        bus.start_i    = 1'b0;
        bus.clr_i      = 1'b0;
        bus.edge_valid = 1'b0;
        n = 5;
        while (!bus.done_o && (n < BUDGET)) begin
            tick();
            n++;
        end
        check("busy_ignore_cycles", 64'(n), 64'd30);
        run_search("busy_ignore_rerun", n);
        check("busy_ignore_color", 64'(bus.color_o), 64'd0);

        // Circulant C30(1,2): 3-colourable as i mod 3, greedy reaches it without backtracking
        clear_graph();
        for (int i = 0; i < NV; i++) begin
            add_edge(i, (i + 1) % NV);
            add_edge(i, (i + 2) % NV);
        end
        run_search("circ", n);
        cv = '0;
        for (int i = 0; i < NV; i++) cv[CW*i +: CW] = CW'(i % 3);
        check("circ_success", 64'(bus.success_o),          64'd1);
        check("circ_color",   64'(bus.color_o),            64'(cv));
        check("circ_checker", 64'(is_proper(bus.color_o)), 64'd1);

        // Random graphs on vertices 0..5 against the exhaustive model
        for (int t = 0; t < 6; t++) begin
            clear_graph();
            for (int i = 0; i < 6; i++)
                for (int j = i + 1; j < 6; j++)
                    if ($urandom_range(99) < 55) add_edge(i, j);
            run_search("rand", n);
            ok = lex_first(6, cv);
            check("rand_success", 64'(bus.success_o), 64'(ok));
            check("rand_timeout", 64'(bus.timeout_o), 64'd0);
            if (ok) check("rand_color", 64'(bus.color_o), 64'(cv));
        end

        // Reset mid-search returns to IDLE with an empty graph
        clear_graph();
        for (int i = 0; i < 5; i++)
            for (int j = i + 1; j < 5; j++) add_edge(i, j);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NV; i++)
            for (int j = 0; j < NV; j++) mg[i][j] = 1'b0;
        check("midrst_busy",  64'(bus.busy_o),     64'd0);
        check("midrst_done",  64'(bus.done_o),     64'd0);
        check("midrst_ready", 64'(bus.edge_ready), 64'd1);
        run_search("midrst_rerun", n);
        check("midrst_cycles", 64'(n),           64'd30);
        check("midrst_color",  64'(bus.color_o), 64'd0);

`ifdef VCGC_CYCLE_LIMIT_EN
        // Budget of 10 search cycles on a 30-vertex search
        bus_t.start_i = 1'b1;
        tick();
        bus_t.start_i = 1'b0;
        n = 0;
        while (!bus_t.done_o && (n < BUDGET)) begin
            tick();
            n++;
        end
        check("tmo_cycles",  64'(n),               64'd10);
        check("tmo_timeout", 64'(bus_t.timeout_o), 64'd1);
        check("tmo_success", 64'(bus_t.success_o), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
